// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register for a {pc, insn} entry.
// Supports stall (blocks acceptance) and flush (drops everything held plus the
// incoming entry, counting the dropped held entries in a saturating counter).
// Optional feature macro PIPE_STAGE_SKID_EN:
//   defined   -> depth 2 (head + skid), in_ready taken from a register, so
//                there is no combinational out_ready -> in_ready path.
//   undefined -> depth 1, in_ready = !stall && (!out_valid || out_ready).
module pipe_stage_reg #(
  parameter int                PC_W     = 32,
  parameter int                INSN_W   = 32,
  parameter logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013,
  parameter int                CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INSN_W-1:0] out_insn,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [1:0]        occ_q, occ_nxt;
  logic [PC_W-1:0]   h_pc_q;
  logic [INSN_W-1:0] h_insn_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_fire, out_fire;
  logic [1:0]        n_drop;
  logic [CNT_W+1:0]  cnt_sum;
  logic [CNT_W-1:0]  cnt_nxt;

  // Handshakes; a flush cycle never accepts the incoming entry.
  assign out_valid = (occ_q != 2'd0);
  assign out_fire  = out_valid && out_ready;
  assign in_fire   = in_valid && in_ready && !flush;

  // Empty stage presents a bubble: pc 0 and the NOP instruction.
  assign out_pc    = out_valid ? h_pc_q : '0;
  assign out_insn  = out_valid ? h_insn_q : NOP_INSN;
  assign occupancy = occ_q;
  assign flush_cnt = cnt_q;

  // An entry dequeued in the flush cycle was delivered, so it is not counted.
  assign n_drop  = occ_q - {1'b0, out_fire};
  assign cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, n_drop};
  assign cnt_nxt = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];

  // Saturating discard counter, advanced only by flush (never by reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (flush) cnt_q <= cnt_nxt;
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= 2'd0;
    else        occ_q <= occ_nxt;
  end

`ifdef PIPE_STAGE_SKID_EN

  logic [PC_W-1:0]   s_pc_q;
  logic [INSN_W-1:0] s_insn_q;
  logic              not_full_q;

  // Registered "room available"; rst_n gating keeps in_ready low during reset
  // while still allowing a transfer on the first edge after release.
  assign in_ready = rst_n && !stall && not_full_q;

  // Next occupancy: flush empties, otherwise +1 / -1 / hold.
  always_comb begin
    occ_nxt = occ_q;
    if (flush) occ_nxt = 2'd0;
    else begin
      unique case ({in_fire, out_fire})
        2'b10:   occ_nxt = occ_q + 2'd1;
        2'b01:   occ_nxt = occ_q - 2'd1;
        default: occ_nxt = occ_q;
      endcase
    end
  end

  // Room flag tracks next occupancy so in_ready never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) not_full_q <= 1'b1;
    else        not_full_q <= (occ_nxt != 2'd2);
  end

  // Head/skid data: pop promotes skid to head; push fills head if empty
  // (or being replaced in a same-cycle push+pop), otherwise the skid slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pc_q   <= '0;
      h_insn_q <= '0;
      s_pc_q   <= '0;
      s_insn_q <= '0;
    end else if (!flush) begin
      if (out_fire) begin
        if (occ_q == 2'd2) begin
          h_pc_q   <= s_pc_q;
          h_insn_q <= s_insn_q;
        end else if (in_fire) begin
          h_pc_q   <= in_pc;
          h_insn_q <= in_insn;
        end
      end else if (in_fire) begin
        if (occ_q == 2'd0) begin
          h_pc_q   <= in_pc;
          h_insn_q <= in_insn;
        end else begin
          s_pc_q   <= in_pc;
          s_insn_q <= in_insn;
        end
      end
    end
  end

`else

  // Single slot: accept when empty or when the head leaves this cycle.
  assign in_ready = rst_n && !stall && (!out_valid || out_ready);

  // Next occupancy for a one-deep stage.
  always_comb begin
    occ_nxt = occ_q;
    if (flush)         occ_nxt = 2'd0;
    else if (in_fire)  occ_nxt = 2'd1;
    else if (out_fire) occ_nxt = 2'd0;
  end

  // Head data loads on every accepted entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_pc_q   <= '0;
      h_insn_q <= '0;
    end else if (in_fire) begin
      h_pc_q   <= in_pc;
      h_insn_q <= in_insn;
    end
  end

`endif

endmodule
